// File: rtl/high_score_tracker_pkg.sv
// Shared definitions for the high-score tracker: score geometry and FSM states.
package high_score_tracker_pkg;

  localparam int SCORE_W = 20;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SNAP      = 3'd1,
    COMPARE   = 3'd2,
    COMMIT    = 3'd3,
    CELEBRATE = 3'd4
  } state_t;

  // True while a game-over comparison is in flight.
  function automatic logic is_busy(input state_t s);
    return (s == SNAP) || (s == COMPARE) || (s == COMMIT);
  endfunction

endpackage

// File: rtl/high_score_tracker_celebrate_timer.sv
// Celebration timer: counts 60 Hz ticks while active and toggles the blink phase.
// `done` flags the tick that ends the celebration so the FSM can leave in the same cycle.
module high_score_tracker_celebrate_timer #(
  parameter int CELEBRATE_TICKS = 180,
  parameter int BLINK_TICKS     = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic tick,
  output logic active,
  output logic blink,
  output logic done
);

  localparam int TW = $clog2(CELEBRATE_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;

  assign done = active && tick && (tick_cnt == TW'(CELEBRATE_TICKS - 1));

  // Tick counter (saturating) plus blink half-period counter; abort wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      blink     <= 1'b0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
    end else if (abort) begin
      active    <= 1'b0;
      blink     <= 1'b0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
    end else if (start) begin
      active    <= 1'b1;
      blink     <= 1'b1;
      tick_cnt  <= '0;
      blink_cnt <= '0;
    end else if (active && tick) begin
      if (tick_cnt != TW'(CELEBRATE_TICKS)) begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      if (done) begin
        active    <= 1'b0;
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/high_score_tracker.sv
// Session best-score tracker. On game over it snapshots the live BCD score,
// compares it digit by digit (most significant first) against the stored best,
// commits strictly greater scores and launches a timed "new record" blink.
// Handshake: the game pulses are single-cycle strobes with no ready/ack; a
// game-over strobe is accepted only in IDLE and dropped otherwise.
module high_score_tracker
  import high_score_tracker_pkg::*;
#(
  parameter int NUM_DIGITS      = 5,
  parameter int CELEBRATE_TICKS = 180,
  parameter int BLINK_TICKS     = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_score,
  input  logic                          i_game_over_pulse,
  input  logic                          i_game_start_pulse,
  input  logic                          i_game_tick_60hz,
  input  logic                          i_show_hi,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_hi_score,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_display_score,
  output logic                          o_new_record,
  output logic                          o_blink,
  output logic                          o_busy,
  output state_t                        dbg_state
);

  localparam int SW = NUM_DIGITS * DIGIT_W;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t          state, state_n;
  logic [SW-1:0]   snapshot, snapshot_n;
  logic [SW-1:0]   hi, hi_n;
  logic [SW-1:0]   display;
  logic [IW-1:0]   idx, idx_n;
  logic            gt, gt_n;
  logic            pending_clear, pending_clear_n;
  logic [DIGIT_W-1:0] snap_digit, hi_digit;
  logic            timer_start, timer_abort, timer_done;
  logic            timer_active, timer_blink;

  // Select the digit pair under the compare index.
  always_comb begin
    snap_digit = '0;
    hi_digit   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        snap_digit = snapshot[i*DIGIT_W +: DIGIT_W];
        hi_digit   = hi[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Next-state and datapath updates; a start strobe seen during the compare
  // (including the COMMIT cycle itself) suppresses the celebration.
  always_comb begin
    state_n         = state;
    snapshot_n      = snapshot;
    idx_n           = idx;
    gt_n            = gt;
    hi_n            = hi;
    pending_clear_n = pending_clear;
    timer_start     = 1'b0;
    timer_abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_game_over_pulse) begin
          state_n         = SNAP;
          pending_clear_n = i_game_start_pulse;
        end
      end
      SNAP: begin
        snapshot_n = i_score;
        idx_n      = IW'(NUM_DIGITS - 1);
        state_n    = COMPARE;
      end
      COMPARE: begin
        if (snap_digit > hi_digit) begin
          gt_n    = 1'b1;
          state_n = COMMIT;
        end else if (snap_digit < hi_digit) begin
          gt_n    = 1'b0;
          state_n = COMMIT;
        end else if (idx == '0) begin
          gt_n    = 1'b0;
          state_n = COMMIT;
        end else begin
          idx_n = idx - IW'(1);
        end
      end
      COMMIT: begin
        if (gt) begin
          hi_n = snapshot;
        end
        if (gt && !(pending_clear || i_game_start_pulse)) begin
          timer_start = 1'b1;
          state_n     = CELEBRATE;
        end else begin
          state_n = IDLE;
        end
      end
      CELEBRATE: begin
        timer_abort = i_game_start_pulse;
        if (i_game_start_pulse || timer_done) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (is_busy(state) && i_game_start_pulse) begin
      pending_clear_n = 1'b1;
    end
    if (state_n == IDLE) begin
      pending_clear_n = 1'b0;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      snapshot      <= '0;
      idx           <= '0;
      gt            <= 1'b0;
      hi            <= '0;
      pending_clear <= 1'b0;
    end else begin
      state         <= state_n;
      snapshot      <= snapshot_n;
      idx           <= idx_n;
      gt            <= gt_n;
      hi            <= hi_n;
      pending_clear <= pending_clear_n;
    end
  end

  // Registered display mux feeding the score renderers.
  always_ff @(posedge clk) begin
    if (rst) begin
      display <= '0;
    end else begin
      display <= i_show_hi ? hi : i_score;
    end
  end

  high_score_tracker_celebrate_timer #(
    .CELEBRATE_TICKS(CELEBRATE_TICKS),
    .BLINK_TICKS    (BLINK_TICKS)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .abort (timer_abort),
    .tick  (i_game_tick_60hz),
    .active(timer_active),
    .blink (timer_blink),
    .done  (timer_done)
  );

  assign o_hi_score      = hi;
  assign o_display_score = display;
  assign o_new_record    = timer_active;
  assign o_blink         = timer_blink;
  assign o_busy          = is_busy(state);
  assign dbg_state       = state;

endmodule

// File: tb/tb_high_score_tracker.sv
// Self-checking bench for high_score_tracker with a behavioural score model.
module tb_high_score_tracker;
  import high_score_tracker_pkg::*;

  localparam int CT = 180;
  localparam int BT = 15;

  logic        clk;
  logic        rst;
  logic [19:0] i_score;
  logic        i_game_over_pulse;
  logic        i_game_start_pulse;
  logic        i_game_tick_60hz;
  logic        i_show_hi;
  logic [19:0] o_hi_score;
  logic [19:0] o_display_score;
  logic        o_new_record;
  logic        o_blink;
  logic        o_busy;
  state_t      dbg_state;

  int          total;
  int          bad;
  logic [19:0] m_hi;
  logic [19:0] exp_q[$];

  high_score_tracker #(
    .NUM_DIGITS(5), .CELEBRATE_TICKS(CT), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk), .rst(rst), .i_score(i_score),
    .i_game_over_pulse(i_game_over_pulse), .i_game_start_pulse(i_game_start_pulse),
    .i_game_tick_60hz(i_game_tick_60hz), .i_show_hi(i_show_hi),
    .o_hi_score(o_hi_score), .o_display_score(o_display_score),
    .o_new_record(o_new_record), .o_blink(o_blink), .o_busy(o_busy),
    .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycles spent in COMPARE: digits examined MS-first until the first difference.
  function automatic int compare_len(input logic [19:0] a, input logic [19:0] b);
    for (int d = 4; d >= 0; d--) begin
      if (a[d*4 +: 4] != b[d*4 +: 4]) return 5 - d;
    end
    return 5;
  endfunction

  // Play one game-over; start_at>0 pulses game_start on that busy cycle.
  task automatic run_game(input logic [19:0] score, input int start_at);
    int   n;
    int   busy_cnt;
    logic rec;
    n   = compare_len(score, m_hi);
    rec = (score > m_hi);
    i_score = score;
    i_game_over_pulse = 1'b1;
    tick_clk();
    i_game_over_pulse = 1'b0;
    busy_cnt = 0;
    while (o_busy && busy_cnt < 20) begin
      busy_cnt++;
      if (busy_cnt == 2) i_score = 20'($urandom);
      if (busy_cnt == start_at) i_game_start_pulse = 1'b1;
      tick_clk();
      i_game_start_pulse = 1'b0;
    end
    check("busy_cycles", 20'(busy_cnt), 20'(n + 2));
    if (rec) m_hi = score;
    exp_q.push_back(m_hi);
    check("hi_score", o_hi_score, exp_q.pop_front());
    check("new_record", 20'(o_new_record), 20'(rec && start_at <= 0));
    check("blink_start", 20'(o_blink), 20'(rec && start_at <= 0));
  endtask

  task automatic abort_celebration();
    i_game_start_pulse = 1'b1;
    tick_clk();
    i_game_start_pulse = 1'b0;
    check("abort_nr", 20'(o_new_record), 20'(0));
    check("abort_blink", 20'(o_blink), 20'(0));
    check("abort_state", 20'(dbg_state), 20'(IDLE));
  endtask

  initial begin
    logic [19:0] s;
    int          mode;
    int          n;
    total = 0;
    bad   = 0;
    m_hi  = '0;
    rst = 1'b1;
    i_score = '0;
    i_game_over_pulse = 1'b0;
    i_game_start_pulse = 1'b0;
    i_game_tick_60hz = 1'b0;
    i_show_hi = 1'b0;
    repeat (3) tick_clk();
    check("rst_hi", o_hi_score, 20'h0);
    check("rst_disp", o_display_score, 20'h0);
    check("rst_flags", {16'h0, o_new_record, o_blink, o_busy, 1'b0}, 20'h0);
    rst = 1'b0;
    tick_clk();

    // directed games
    run_game(20'h00123, 0);
    abort_celebration();
    run_game(20'h00500, 0);
    abort_celebration();
    run_game(20'h00499, 0);
    run_game(20'h00500, 0);
    run_game(20'h00600, 3);
    run_game(20'h00601, 3);
    check("pending_cleared", 20'(o_new_record), 20'(0));

    // full celebration
    run_game(20'h00700, 0);
    for (int k = 1; k <= CT; k++) begin
      i_game_tick_60hz = 1'b1;
      tick_clk();
      i_game_tick_60hz = 1'b0;
      check("cel_nr", 20'(o_new_record), 20'(k < CT));
      check("cel_blink", 20'(o_blink), 20'((k < CT) && ((k / BT) % 2 == 0)));
      if (k == 50) begin
        i_show_hi = 1'b1;
        i_score = 20'h00042;
        tick_clk();
        check("show_hi_on", o_display_score, m_hi);
        i_show_hi = 1'b0;
        tick_clk();
        check("show_hi_off", o_display_score, 20'h00042);
      end
      if (k == 60) begin
        i_game_over_pulse = 1'b1;
        tick_clk();
        i_game_over_pulse = 1'b0;
        check("gameover_ignored", 20'(o_busy), 20'(0));
      end
      repeat ($urandom_range(0, 1)) tick_clk();
    end
    check("cel_end_state", 20'(dbg_state), 20'(IDLE));

    // randomized games against the model
    for (int g = 0; g < 24; g++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: s = 20'($urandom);
        1: s = m_hi;
        2: begin
          s = m_hi;
          n = $urandom_range(0, 4);
          s[n*4 +: 4] = 4'($urandom_range(0, 15));
        end
        default: s = 20'($urandom_range(0, 20'h00fff));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        run_game(s, $urandom_range(1, compare_len(s, m_hi) + 2));
      end else begin
        run_game(s, 0);
      end
      if (o_new_record) abort_celebration();
      i_show_hi = 1'($urandom_range(0, 1));
      i_score = 20'($urandom);
      tick_clk();
      check("rand_disp", o_display_score, i_show_hi ? m_hi : i_score);
    end

    // reset during COMPARE
    i_score = 20'hfffff;
    i_game_over_pulse = 1'b1;
    tick_clk();
    i_game_over_pulse = 1'b0;
    repeat (2) tick_clk();
    check("pre_rst_busy", 20'(o_busy), 20'(1));
    rst = 1'b1;
    tick_clk();
    m_hi = '0;
    check("midrst_hi", o_hi_score, m_hi);
    check("midrst_disp", o_display_score, 20'h0);
    check("midrst_flags", {16'h0, o_new_record, o_blink, o_busy, 1'b0}, 20'h0);
    rst = 1'b0;
    tick_clk();
    run_game(20'h00001, 0);
    abort_celebration();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
